// File: rtl/adder_pkg.sv
// Shared widths, helper functions and sideband type for the pipelined adder tree.
package adder_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int sum_width(input int num_in, input int in_w);
      return in_w + clog2(num_in);
   endfunction

   function automatic int out_width(input int num_in, input int in_w, input int acc_extra);
      return sum_width(num_in, in_w) + acc_extra;
   endfunction

   // Bit offset of tree level lvl inside the flattened bus of all levels (level 0 = operands).
   function automatic int level_off(input int num_in, input int in_w, input int lvl);
      int o;
      o = 0;
      for (int j = 0; j < lvl; j++) o += (num_in >> j) * (in_w + j);
      return o;
   endfunction

   typedef struct packed {
      logic last;
      logic acc;
      logic valid;
   } side_t;

endpackage

// File: rtl/adder_tree_level.sv
// One registered rank of the adder tree: adds adjacent operand pairs, one bit wider out.
module adder_tree_level
   import adder_pkg::*;
#(
   parameter int PAIRS = 2,
   parameter int IN_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      adv,
   input  logic [2*PAIRS*IN_W-1:0]   in_data,
   input  side_t                     in_side,
   output logic [PAIRS*(IN_W+1)-1:0] out_data,
   output side_t                     out_side
);

   localparam int OW = IN_W + 1;

   logic [PAIRS*OW-1:0] sum;

   always_comb begin
      sum = '0;
      for (int p = 0; p < PAIRS; p++) begin
         sum[p*OW +: OW] = OW'(in_data[(2*p)*IN_W +: IN_W]) + OW'(in_data[(2*p+1)*IN_W +: IN_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_side <= '0;
      end else if (adv) begin
         out_side <= in_side;
      end
   end

   // Data rank carries no reset; its valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (adv) begin
         out_data <= sum;
      end
   end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_IN-operand adder tree with valid/ready flow control and frame accumulation.
module adder_tree_pipe
   import adder_pkg::*;
#(
   parameter int NUM_IN    = 4,
   parameter int IN_W      = 4,
   parameter int ACC_EXTRA = 8,
   localparam int LEVELS   = clog2(NUM_IN),
   localparam int SUM_W    = sum_width(NUM_IN, IN_W),
   localparam int OUT_W    = out_width(NUM_IN, IN_W, ACC_EXTRA)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUM_IN*IN_W-1:0] in_data,
   input  logic                   in_last,
   input  logic                   in_acc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_last,
   output logic                   out_ovf
);

   localparam int TREE_W   = level_off(NUM_IN, IN_W, LEVELS + 1);
   localparam int LAST_OFF = level_off(NUM_IN, IN_W, LEVELS);

   function automatic logic [OUT_W:0] acc_add(input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   logic [TREE_W-1:0] tree;
   side_t             side [0:LEVELS];
   logic              adv;
   logic [OUT_W-1:0]  acc;
   logic              ovf_sticky;
   logic [OUT_W-1:0]  sum_ext;
   logic [OUT_W:0]    acc_next;
   side_t             side_l;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign tree[NUM_IN*IN_W-1:0] = in_data;
   assign side[0] = '{last: in_last, acc: in_acc, valid: in_valid};

   for (genvar s = 1; s <= LEVELS; s++) begin : g_level
      localparam int W     = IN_W + s - 1;
      localparam int PAIRS = NUM_IN >> s;
      adder_tree_level #(
         .PAIRS (PAIRS),
         .IN_W  (W)
      ) u_level (
         .clk      (clk),
         .rst      (rst),
         .adv      (adv),
         .in_data  (tree[level_off(NUM_IN, IN_W, s-1) +: 2*PAIRS*W]),
         .in_side  (side[s-1]),
         .out_data (tree[level_off(NUM_IN, IN_W, s) +: PAIRS*(W+1)]),
         .out_side (side[s])
      );
   end

   assign side_l   = side[LEVELS];
   assign sum_ext  = OUT_W'(tree[LAST_OFF +: SUM_W]);
   assign acc_next = acc_add(acc, sum_ext);

   // Output register and frame accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_ovf    <= 1'b0;
         acc        <= '0;
         ovf_sticky <= 1'b0;
      end else if (adv) begin
         out_valid <= 1'b0;
         if (side_l.valid) begin
            if (!side_l.acc) begin
               out_valid <= 1'b1;
               out_data  <= sum_ext;
               out_last  <= side_l.last;
               out_ovf   <= 1'b0;
            end else if (!side_l.last) begin
               acc        <= acc_next[OUT_W-1:0];
               ovf_sticky <= ovf_sticky | acc_next[OUT_W];
            end else begin
               out_valid  <= 1'b1;
               out_data   <= acc_next[OUT_W-1:0];
               out_last   <= 1'b1;
               out_ovf    <= ovf_sticky | acc_next[OUT_W];
               acc        <= '0;
               ovf_sticky <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: default instance plus an ACC_EXTRA=0 instance for wrap tests.
module tb_adder_tree_pipe;

   typedef struct packed {
      logic [15:0] ops;
      logic        last;
      logic        acc;
      logic [13:0] exp_data;
      logic        exp_last;
   } vec_t;

   typedef struct packed {
      logic [13:0] data;
      logic        last;
      logic        ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [15:0] in_data;
   logic        in_last;
   logic        in_acc;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [13:0] out_data;
   logic [5:0]  out_data2;
   logic        out_last, out_last2;
   logic        out_ovf, out_ovf2;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   res_t q1[$];
   res_t q2[$];
   int   qc[$];
   vec_t vecs[5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adder_tree_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_acc    (in_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ovf   (out_ovf)
   );

   adder_tree_pipe #(.ACC_EXTRA(0)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_acc    (in_acc),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_data  (out_data2),
      .out_last  (out_last2),
      .out_ovf   (out_ovf2)
   );

   // Record every result handed over to the consumer, in order.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q1.push_back('{data: out_data, last: out_last, ovf: out_ovf});
         qc.push_back(cyc);
      end
      if (out_valid2 && out_ready) begin
         q2.push_back('{data: 14'(out_data2), last: out_last2, ovf: out_ovf2});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] ops, input logic last, input logic acc);
      in_valid = 1'b1;
      in_data  = ops;
      in_last  = last;
      in_acc   = acc;
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_acc   = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   int          idx;
   logic [13:0] held;
   logic [3:0]  nib;

   initial begin
      vecs[0] = '{16'hFFFF, 1'b1, 1'b0, 14'd60, 1'b1};
      vecs[1] = '{16'h4321, 1'b0, 1'b0, 14'd10, 1'b0};
      vecs[2] = '{16'h0000, 1'b1, 1'b0, 14'd0,  1'b1};
      vecs[3] = '{16'h000F, 1'b1, 1'b1, 14'd15, 1'b1};
      vecs[4] = '{16'hA987, 1'b0, 1'b0, 14'd34, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_acc = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data),  0);
      chk("rst_out_last",  32'(out_last),  0);
      chk("rst_out_ovf",   32'(out_ovf),   0);
      rst = 1'b0;
      step();
      chk("rst_in_ready",  32'(in_ready),  1);

      // Single beats through the full pipeline, one at a time
      for (int v = 0; v < 5; v++) begin
         beat(vecs[v].ops, vecs[v].last, vecs[v].acc);
         idle(1);
         chk("lat_not_early", 32'(out_valid), 0);
         step();
         @(negedge clk);
         chk("vec_valid", 32'(out_valid), 1);
         chk("vec_data",  32'(out_data),  32'(vecs[v].exp_data));
         chk("vec_last",  32'(out_last),  32'(vecs[v].exp_last));
         chk("vec_ovf",   32'(out_ovf),   0);
         step(); step();
      end

      // Back-to-back streaming
      q1.delete(); qc.delete();
      for (int k = 0; k < 8; k++) begin
         chk("stream_in_ready", 32'(in_ready), 1);
         nib = 4'(k);
         beat({4{nib}}, 1'b0, 1'b0);
      end
      idle(6);
      chk("stream_count", 32'(q1.size()), 8);
      for (int i = 0; i < q1.size(); i++) begin
         chk("stream_data", 32'(q1[i].data), 32'(4*i));
         if (i > 0) chk("stream_consecutive", 32'(qc[i] - qc[i-1]), 1);
      end

      // Backpressure for 5 cycles mid-stream
      q1.delete();
      idx = 0;
      held = '0;
      for (int c = 0; c < 31; c++) begin
         step();
         out_ready = !(c >= 4 && c < 9);
         if (idx < 10) begin
            nib      = 4'(idx + 1);
            in_valid = 1'b1;
            in_data  = {4{nib}};
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (c == 4) held = out_data;
         if (c >= 5 && c < 9) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_frozen",   32'(out_data), 32'(held));
         end
         if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      idle(2);
      chk("bp_accepted", 32'(idx), 10);
      chk("bp_count", 32'(q1.size()), 10);
      for (int i = 0; i < q1.size(); i++) chk("bp_data", 32'(q1[i].data), 32'(4*(i+1)));

      // Accumulate frame, then a fresh single-beat frame
      q1.delete();
      beat(16'h4321, 1'b0, 1'b1);
      beat(16'h5555, 1'b0, 1'b1);
      beat(16'h000F, 1'b1, 1'b1);
      idle(6);
      chk("acc_count", 32'(q1.size()), 1);
      if (q1.size() > 0) begin
         chk("acc_data", 32'(q1[0].data), 45);
         chk("acc_last", 32'(q1[0].last), 1);
         chk("acc_ovf",  32'(q1[0].ovf),  0);
      end
      q1.delete();
      beat(16'h2222, 1'b1, 1'b1);
      idle(6);
      chk("acc_next_count", 32'(q1.size()), 1);
      if (q1.size() > 0) chk("acc_next_data", 32'(q1[0].data), 8);

      // Sum beat inside an open accumulate frame
      q1.delete();
      beat(16'h1111, 1'b0, 1'b1);
      beat(16'h3333, 1'b0, 1'b0);
      beat(16'h2222, 1'b1, 1'b1);
      idle(6);
      chk("mix_count", 32'(q1.size()), 2);
      if (q1.size() == 2) begin
         chk("mix_sum_data",  32'(q1[0].data), 12);
         chk("mix_sum_last",  32'(q1[0].last), 0);
         chk("mix_acc_data",  32'(q1[1].data), 12);
         chk("mix_acc_last",  32'(q1[1].last), 1);
      end

      // Accumulator wrap with no guard bits
      q1.delete(); q2.delete();
      beat(16'hFFFF, 1'b0, 1'b1);
      beat(16'hFFFF, 1'b1, 1'b1);
      idle(6);
      chk("ovf_count", 32'(q2.size()), 1);
      if (q2.size() > 0) begin
         chk("ovf_data", 32'(q2[0].data), 56);
         chk("ovf_flag", 32'(q2[0].ovf),  1);
         chk("ovf_last", 32'(q2[0].last), 1);
      end
      if (q1.size() > 0) begin
         chk("wide_data", 32'(q1[0].data), 120);
         chk("wide_ovf",  32'(q1[0].ovf),  0);
      end
      q2.delete();
      beat(16'hFFFF, 1'b1, 1'b1);
      idle(6);
      chk("ovf_next_count", 32'(q2.size()), 1);
      if (q2.size() > 0) begin
         chk("ovf_next_data", 32'(q2[0].data), 60);
         chk("ovf_next_flag", 32'(q2[0].ovf),  0);
      end

      // Reset in the middle of an accumulate frame
      q1.delete();
      beat(16'h7777, 1'b0, 1'b1);
      beat(16'h7777, 1'b0, 1'b1);
      idle(2);
      rst = 1'b1;
      step();
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_in_ready",  32'(in_ready),  1);
      rst = 1'b0;
      beat(16'h1111, 1'b1, 1'b1);
      idle(6);
      chk("post_rst_count", 32'(q1.size()), 1);
      if (q1.size() > 0) begin
         chk("post_rst_data", 32'(q1[0].data), 4);
         chk("post_rst_ovf",  32'(q1[0].ovf),  0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
